// File: rtl/operand_collector_pkg.sv
// Shared definitions for the operand collector: default operand width,
// group size and the collector state encoding.
package operand_collector_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned NOPS          = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } oc_state_e;

endpackage

// File: rtl/operand_collector.sv
// Gathers a serial operand stream into groups of up to four parallel operands
// for a downstream 4-input adder, with valid/ready handshakes on both sides.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [2:0]       out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  oc_state_e        state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0]       count_q, count_d;
  logic [WIDTH-1:0] slot_q [NOPS];
  logic [WIDTH-1:0] slot_d [NOPS];
  logic             in_hs;

  assign in_ready = (state_q == COLLECT) ? 1'b1 : out_ready;
  assign in_hs    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    slot_d  = slot_q;

    if (flush) begin
      for (int unsigned i = 0; i < NOPS; i++) slot_d[i] = '0;
      idx_d   = '0;
      count_d = '0;
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (in_hs) begin
            slot_d[idx_q] = in_data;
            if (idx_q == 2'd3 || in_last) begin
              // idx stays put on the final operand so it never wraps in a group
              state_d = HOLD;
              count_d = {1'b0, idx_q} + 3'd1;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            for (int unsigned i = 0; i < NOPS; i++) slot_d[i] = '0;
            idx_d   = '0;
            count_d = '0;
            state_d = COLLECT;
            // Same-cycle handoff: the accepted operand opens the next group
            if (in_hs) begin
              slot_d[0] = in_data;
              idx_d     = 2'd1;
              if (in_last) begin
                state_d = HOLD;
                count_d = 3'd1;
              end
            end
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < NOPS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

  assign out_a     = slot_q[0];
  assign out_b     = slot_q[1];
  assign out_c     = slot_q[2];
  assign out_d     = slot_q[3];
  assign out_count = count_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; fixed operand group size of 4.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: flush  input  1  synchronous discard of the partial or held group.
REQ-005 SHALL have port: in_data  input  WIDTH  serial operand stream.
REQ-006 SHALL have port: in_valid  input  1  in_data valid.
REQ-007 SHALL have port: in_last  input  1  marks final operand of a short group (1-3 operands).
REQ-008 SHALL have port: in_ready  output  1  collector accepts in_data this cycle.
REQ-009 SHALL have ports: out_a, out_b, out_c, out_d  output  WIDTH each  parallel operands for the downstream 4-operand adder.
REQ-010 SHALL have port: out_count  output  3  number of real operands in the group, 1..4.
REQ-011 SHALL have port: out_valid  output  1  group complete and stable.
REQ-012 SHALL have port: out_ready  input  1  downstream consumes the group.

Function
REQ-013 SHALL implement two states: COLLECT (filling slots) and HOLD (presenting the group).
REQ-014 SHALL complete an input handshake when in_valid and in_ready are both 1; data goes to slot idx (0=a, 1=b, 2=c, 3=d), and idx increments.
REQ-015 SHALL, in COLLECT, drive in_ready=1 and out_valid=0.
REQ-016 SHALL move COLLECT->HOLD on the handshake with idx==3 or with in_last=1; out_valid rises the next cycle (latency 1 cycle from the final handshake).
REQ-017 SHALL keep unfilled slots of a short group at 0, so the downstream sum is unaffected; out_count equals idx+1 at the final handshake.
REQ-018 SHALL, in HOLD, drive out_valid=1 and hold out_a..out_d and out_count stable until out_valid and out_ready are both 1.
REQ-019 SHALL, in HOLD, drive in_ready=out_ready (back-to-back handoff).
REQ-020 SHALL, on a handoff cycle with an accepted input, clear all slots, write in_data into slot a, and set idx=1.
REQ-021 SHALL, on a handoff cycle, transition to COLLECT, unless the accepted input also has in_last=1; in that case it re-enters HOLD with out_count=1.
REQ-022 SHALL, on a handoff cycle with no accepted input, clear all slots, set idx=0, and go to COLLECT.
REQ-023 SHALL treat flush as highest priority: slots cleared, idx=0, state COLLECT, and any concurrent input handshake dropped; in_ready stays as defined by the current state.
REQ-024 SHALL treat in_last on the 4th operand the same as a normal full group.
REQ-025 SHALL never let idx exceed 3 or wrap inside a group.
REQ-026 SHALL NOT let in_data change out_a..out_d combinationally; all outputs are register-driven except in_ready.

Reset
REQ-027 SHALL, on asynchronous assertion of rst_n=0 (including mid-group or mid-HOLD), immediately set state=COLLECT, idx=0, out_a..out_d=0, out_count=0, and out_valid=0.
REQ-028 SHALL drive in_ready=1 once rst_n deasserts; deassertion is synchronised to clk by the integrator, not by this block.

Structure
REQ-029 SHALL place WIDTH default, NOPS=4, and the state enum (COLLECT, HOLD) in shared package operand_collector_pkg.
REQ-030 SHALL be a single flat module with no sub-module; the downstream adder is instantiated by the parent, not inside this block.

Verification
REQ-031 SHALL cover full group: 0x01,0x02,0x03,0x04 on consecutive cycles with out_ready=1 -> out_valid 1 cycle after the 4th operand; a..d=01,02,03,04; out_count=4; adder sum=0x00A.
REQ-032 SHALL cover max values: four 0xFF -> a..d=0xFF, out_count=4, downstream sum=0x3FC with no truncation.
REQ-033 SHALL cover short group: 0x10, then 0x20 with in_last=1 -> a=0x10, b=0x20, c=d=0, out_count=2.
REQ-034 SHALL cover backpressure and handoff: out_ready=0 for 5 cycles in HOLD -> outputs stable and in_ready=0. Then out_ready=1 with in_valid=1, in_data=0x55 -> same-cycle handoff; next group has a=0x55, idx=1.
REQ-035 SHALL cover flush: flush=1 after 2 operands with concurrent in_valid -> no out_valid, and the next 4 operands form a clean group.
REQ-036 SHALL cover reset: rst_n pulsed low mid-HOLD -> out_valid=0 and all outputs 0 asynchronously; the collector resumes with a clean group.
